wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 81 ++++++++
 tb/tb_wb_regfile.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage + architectural register file: writeback mux, two combinational read ports,
// registered forward copy of the last commit, and a retire counter. Optional macro: WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] MEMWB_read_data,
    input  logic [XLEN-1:0] MEMWB_Result,
    input  logic            MEMWB_MemtoReg,
    input  logic            MEMWB_RegWrite,
    input  logic [4:0]      MEMWB_inst2,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_fwd_valid,
    output logic [4:0]      wb_fwd_rd,
    output logic [XLEN-1:0] wb_fwd_data,
    output logic [31:0]     retire_count
);

    logic [XLEN-1:0] r_regs [NREG];
    logic            r_fwd_valid;
    logic [4:0]      r_fwd_rd;
    logic [XLEN-1:0] r_fwd_data;
    logic [31:0]     r_retire_count;

    logic            w_commit;
    logic [31:0]     w_retire_cur;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    assign wb_data = MEMWB_MemtoReg ? MEMWB_read_data : MEMWB_Result;

    // x0 writes are architectural no-ops; gating with reset also drops commits during reset
    assign w_commit = MEMWB_RegWrite && (MEMWB_inst2 != 5'd0) && reset;

    // Counter next-state is taken from this net so the current count has a single observation point
    assign w_retire_cur = r_retire_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_fwd_valid    <= 1'b0;
            r_fwd_rd       <= 5'd0;
            r_fwd_data     <= '0;
            r_retire_count <= 32'd0;
        end else begin
            r_fwd_valid <= w_commit;
            if (w_commit) begin
                r_regs[MEMWB_inst2] <= wb_data;
                r_fwd_rd            <= MEMWB_inst2;
                r_fwd_data          <= wb_data;
                r_retire_count      <= w_retire_cur + 32'd1;
            end
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (reset && (rs1 != 5'd0)) w_rd1 = r_regs[rs1];
        if (reset && (rs2 != 5'd0)) w_rd2 = r_regs[rs2];
`ifdef WB_REGFILE_BYPASS_EN
        // Write-before-read: a same-cycle commit is visible to decode immediately
        if (w_commit && (rs1 == MEMWB_inst2)) w_rd1 = wb_data;
        if (w_commit && (rs2 == MEMWB_inst2)) w_rd2 = wb_data;
`endif
    end

    assign ReadData1    = w_rd1;
    assign ReadData2    = w_rd2;
    assign wb_fwd_valid = r_fwd_valid;
    assign wb_fwd_rd    = r_fwd_rd;
    assign wb_fwd_data  = r_fwd_data;
    assign retire_count = w_retire_cur;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed literal checks plus randomized traffic
// compared every cycle against an array-based register-file model.
module tb_wb_regfile;
    localparam int XLEN = 64;

    logic            clk;
    logic            reset;
    logic [XLEN-1:0] MEMWB_read_data;
    logic [XLEN-1:0] MEMWB_Result;
    logic            MEMWB_MemtoReg;
    logic            MEMWB_RegWrite;
    logic [4:0]      MEMWB_inst2;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] ReadData1;
    logic [XLEN-1:0] ReadData2;
    logic [XLEN-1:0] wb_data;
    logic            wb_fwd_valid;
    logic [4:0]      wb_fwd_rd;
    logic [XLEN-1:0] wb_fwd_data;
    logic [31:0]     retire_count;

    wb_regfile #(.XLEN(XLEN), .NREG(32)) dut (
        .clk(clk), .reset(reset),
        .MEMWB_read_data(MEMWB_read_data), .MEMWB_Result(MEMWB_Result),
        .MEMWB_MemtoReg(MEMWB_MemtoReg), .MEMWB_RegWrite(MEMWB_RegWrite),
        .MEMWB_inst2(MEMWB_inst2), .rs1(rs1), .rs2(rs2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .wb_data(wb_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference state
    logic [XLEN-1:0] m_regs [32];
    bit              m_fwd_valid;
    logic [4:0]      m_fwd_rd;
    logic [XLEN-1:0] m_fwd_data;
    logic [31:0]     m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_fwd_valid = 1'b0;
        m_fwd_rd    = 5'd0;
        m_fwd_data  = '0;
        m_count     = 32'd0;
    endtask

    function automatic logic [XLEN-1:0] exp_wb();
        return MEMWB_MemtoReg ? MEMWB_read_data : MEMWB_Result;
    endfunction

    function automatic bit exp_commit();
        return reset && MEMWB_RegWrite && (MEMWB_inst2 != 5'd0);
    endfunction

    function automatic logic [XLEN-1:0] exp_read(input logic [4:0] idx);
        if (!reset) return '0;
        if (BYPASS && exp_commit() && idx == MEMWB_inst2) return exp_wb();
        return m_regs[idx];
    endfunction

    // Model advance on each rising edge using the inputs present at that edge
    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_fwd_valid = exp_commit();
            if (exp_commit()) begin
                m_regs[MEMWB_inst2] = exp_wb();
                m_fwd_rd            = MEMWB_inst2;
                m_fwd_data          = exp_wb();
                m_count             = m_count + 32'd1;
            end
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("wb_data",      wb_data,              exp_wb());
            chk("ReadData1",    ReadData1,            exp_read(rs1));
            chk("ReadData2",    ReadData2,            exp_read(rs2));
            chk("wb_fwd_valid", 64'(wb_fwd_valid),    64'(m_fwd_valid));
            chk("wb_fwd_rd",    64'(wb_fwd_rd),       64'(m_fwd_rd));
            chk("wb_fwd_data",  wb_fwd_data,          m_fwd_data);
            chk("retire_count", 64'(retire_count),    64'(m_count));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input bit m2r, input logic [63:0] rdata,
                         input logic [63:0] res, input logic [4:0] rd);
        MEMWB_RegWrite  = we;
        MEMWB_MemtoReg  = m2r;
        MEMWB_read_data = rdata;
        MEMWB_Result    = res;
        MEMWB_inst2     = rd;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 5'd0);
        rs1 = 5'd0;
        rs2 = 5'd0;
        m_clear();
        chk_en = 1'b1;
        tick();
        rs1 = 5'd5;
        rs2 = 5'd31;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst ReadData1",    ReadData1, 64'h0);
        chk("rst ReadData2",    ReadData2, 64'h0);
        chk("rst retire_count", 64'(retire_count), 64'h0);
        chk("rst fwd_valid",    64'(wb_fwd_valid), 64'h0);

        // ALU result commit to x7
        tick();
        drive(1'b1, 1'b0, 64'hBAD, 64'h1234, 5'd7);
        rs1 = 5'd7;
        @(negedge clk);
        chk("wb_data alu", wb_data, 64'h1234);
        chk("x7 same-cycle", ReadData1, BYPASS ? 64'h1234 : 64'h0);
        tick();
        MEMWB_RegWrite = 1'b0;
        @(negedge clk);
        chk("x7 read",     ReadData1, 64'h1234);
        chk("x7 fwd_valid", 64'(wb_fwd_valid), 64'h1);
        chk("x7 fwd_rd",    64'(wb_fwd_rd), 64'h7);
        chk("x7 fwd_data",  wb_fwd_data, 64'h1234);
        chk("x7 count",     64'(retire_count), 64'h1);

        // Load to x0 is discarded
        tick();
        drive(1'b1, 1'b1, 64'hDEAD, 64'h0, 5'd0);
        rs1 = 5'd0;
        @(negedge clk);
        chk("wb_data load", wb_data, 64'hDEAD);
        tick();
        MEMWB_RegWrite = 1'b0;
        @(negedge clk);
        chk("x0 read",      ReadData1, 64'h0);
        chk("x0 count",     64'(retire_count), 64'h1);
        chk("x0 fwd_valid", 64'(wb_fwd_valid), 64'h0);
        chk("x0 fwd_data hold", wb_fwd_data, 64'h1234);

        // Same-cycle read of a register being written
        tick();
        drive(1'b1, 1'b0, '0, 64'h77, 5'd3);
        tick();
        drive(1'b1, 1'b0, '0, 64'hAA, 5'd3);
        rs2 = 5'd3;
        @(negedge clk);
        chk("x3 same-cycle", ReadData2, BYPASS ? 64'hAA : 64'h77);
        tick();
        MEMWB_RegWrite = 1'b0;
        @(negedge clk);
        chk("x3 next-cycle", ReadData2, 64'hAA);
        chk("x3 count",      64'(retire_count), 64'h3);

        // Counter wrap
        chk_en = 1'b0;
        force dut.w_retire_cur = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, '0, 64'h11, 5'd1);
        @(negedge clk);
        chk("forced count", 64'(retire_count), 64'hFFFF_FFFF);
        tick();
        release dut.w_retire_cur;
        MEMWB_RegWrite = 1'b0;
        m_count = 32'd0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("wrap count", 64'(retire_count), 64'h0);

        // Async reset mid-cycle
        tick();
        drive(1'b1, 1'b0, '0, 64'h55, 5'd9);
        tick();
        MEMWB_RegWrite = 1'b0;
        rs1 = 5'd9;
        @(negedge clk);
        chk("x9 read", ReadData1, 64'h55);
        tick();
        #2;
        reset = 1'b0;
        m_clear();
        drive(1'b1, 1'b0, '0, 64'h44, 5'd4);
        #1;
        chk("async x9",        ReadData1, 64'h0);
        chk("async count",     64'(retire_count), 64'h0);
        chk("async fwd_valid", 64'(wb_fwd_valid), 64'h0);
        chk("async fwd_data",  wb_fwd_data, 64'h0);
        chk("wb_data in rst",  wb_data, 64'h44);
        tick();
        reset = 1'b1;
        rs1 = 5'd4;
        @(negedge clk);
        chk("dropped in rst",  64'(retire_count), 64'h0);
        tick();
        MEMWB_RegWrite = 1'b0;
        @(negedge clk);
        chk("first commit",    64'(retire_count), 64'h1);
        chk("x4 read",         ReadData1, 64'h44);

        // Randomized traffic; small index range biases toward hazards and repeats
        for (int n = 0; n < 400; n++) begin
            tick();
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)));
            rs1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) begin
                rs1 = MEMWB_inst2;
            end
        end
        tick();
        MEMWB_RegWrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
